// File: rtl/debounce_sync.sv
// debounce_sync: N-stage synchroniser, tick-qualified stability counter and STABLE/CHECK FSM
// that turn a raw asynchronous level into a clean level q. Define DEBOUNCE_EDGE_EN for rise/fall pulses.
module debounce_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  input  logic tick,
  output logic q,
  output logic busy,
  output logic rise,
  output logic fall
);

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   commit;

  // NOTE: the synchroniser stages are reset too, so a level held on d_in during reset
  // cannot leak into q straight after release; it must requalify from scratch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its neighbour's old value.
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Next-state logic; commit marks the edge at which q takes the synchronised value.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable unassigned (latch).
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    unique case (state)
      STABLE: begin
        cnt_nxt = '0;
        if (s != q && tick) begin
          if (STABLE_CYCLES == 1) begin
            commit = 1'b1;
          end else begin
            state_nxt = CHECK;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      CHECK: begin
        if (s == q) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (tick && cnt == CNT_LAST) begin
          commit    = 1'b1;
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (tick) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= STABLE;
      cnt   <= '0;
      q     <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt == CHECK);
      if (commit) q <= s;
    end
  end

`ifdef DEBOUNCE_EDGE_EN
  // Pulses register on the same edge that updates q, so they line up with the new level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= commit & s;
      fall <= commit & ~s;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: directed vector table, hand-written reset sequences,
// and randomized stimulus compared against a rule-level reference model.
module tb_debounce_sync;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 4;
  localparam int CNT_W         = 16;
`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic d_in = 1'b0;
  logic tick = 1'b1;
  logic q, busy, rise, fall;

  int n_checks = 0;
  int n_fail   = 0;

  debounce_sync #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .d_in (d_in),
    .tick (tick),
    .q    (q),
    .busy (busy),
    .rise (rise),
    .fall (fall)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit d_in;
    bit tick;
    bit q;
    bit busy;
    bit rise;
    bit fall;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: s is d_in delayed by SYNC_STAGES edges; q flips once the mismatch
  // has been seen on STABLE_CYCLES tick edges without an intervening match.
  bit dq[$];
  bit m_q, m_busy, m_rise, m_fall;
  int m_run;

  task automatic model_reset();
    dq = {};
    repeat (SYNC_STAGES) dq.push_back(1'b0);
    m_q = 0; m_busy = 0; m_rise = 0; m_fall = 0; m_run = 0;
  endtask

  task automatic model_edge(input bit din, input bit tk);
    bit s_use;
    s_use = dq.pop_front();
    dq.push_back(din);
    m_rise = 0;
    m_fall = 0;
    if (s_use == m_q) begin
      m_run  = 0;
      m_busy = 0;
    end else if (tk) begin
      m_run++;
      if (m_run == STABLE_CYCLES) begin
        m_q    = s_use;
        m_rise = s_use;
        m_fall = !s_use;
        m_run  = 0;
        m_busy = 0;
      end else begin
        m_busy = 1;
      end
    end else begin
      m_busy = (m_run > 0);
    end
  endtask

  task automatic cycle(input bit din, input bit tk, input string tag);
    d_in = din;
    tick = tk;
    @(posedge clk);
    model_edge(din, tk);
    #1;
    check({tag, " q"},    q,    m_q);
    check({tag, " busy"}, busy, m_busy);
    check({tag, " rise"}, rise, m_rise & EDGE_EN);
    check({tag, " fall"}, fall, m_fall & EDGE_EN);
  endtask

  task automatic add(input bit d, input bit t, input bit eq, input bit eb, input bit er, input bit ef);
    vec_t v;
    v.d_in = d; v.tick = t; v.q = eq; v.busy = eb; v.rise = er; v.fall = ef;
    vecs.push_back(v);
  endtask

  initial begin
    int first_q;
    bit din;

    // Rise from q=0: busy edges 3..5, q and rise at edge 6.
    add(1,1, 0,0,0,0); add(1,1, 0,0,0,0); add(1,1, 0,1,0,0); add(1,1, 0,1,0,0);
    add(1,1, 0,1,0,0); add(1,1, 1,0,1,0); add(1,1, 1,0,0,0); add(1,1, 1,0,0,0);
    // Fall from q=1: fall pulses once at edge 6.
    add(0,1, 1,0,0,0); add(0,1, 1,0,0,0); add(0,1, 1,1,0,0); add(0,1, 1,1,0,0);
    add(0,1, 1,1,0,0); add(0,1, 0,0,0,1); add(0,1, 0,0,0,0); add(0,1, 0,0,0,0);
    // Three-cycle glitch: busy rises and clears, q never moves.
    add(1,1, 0,0,0,0); add(1,1, 0,0,0,0); add(1,1, 0,1,0,0); add(0,1, 0,1,0,0);
    add(0,1, 0,1,0,0); add(0,1, 0,0,0,0); add(0,1, 0,0,0,0); add(0,1, 0,0,0,0);

    // Reset held with d_in=1; outputs clear without a clock edge.
    #1;
    d_in = 1'b1;
    rst  = 1'b0;
    model_reset();
    #1;
    check("async reset q", q, 1'b0);
    check("async reset busy", busy, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
      check("reset q", q, 1'b0);
      check("reset busy", busy, 1'b0);
      check("reset rise", rise, 1'b0);
      check("reset fall", fall, 1'b0);
    end

    rst = 1'b1;
    foreach (vecs[i]) begin
      d_in = vecs[i].d_in;
      tick = vecs[i].tick;
      @(posedge clk);
      model_edge(vecs[i].d_in, vecs[i].tick);
      #1;
      check($sformatf("vec%0d q", i),    q,    vecs[i].q);
      check($sformatf("vec%0d busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d rise", i), rise, vecs[i].rise & EDGE_EN);
      check($sformatf("vec%0d fall", i), fall, vecs[i].fall & EDGE_EN);
    end

    // Tick on alternate cycles only; busy must hold across idle edges.
    for (int i = 0; i < 20; i++) cycle(1'b1, (i % 2) == 0, "alt_tick");
    check("alt_tick final q", q, 1'b1);

    // Asynchronous reset while q=1, asserted between clock edges.
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("mid-cycle reset q", q, 1'b0);
    check("mid-cycle reset busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset mid-CHECK (cnt=2) aborts counting; full latency is needed again.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, "pre_abort");
    check("pre_abort busy", busy, 1'b1);
    rst = 1'b0;
    model_reset();
    #1;
    check("abort q", q, 1'b0);
    check("abort busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    first_q = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b1, "post_abort");
      if (first_q == 0 && q === 1'b1) first_q = i;
    end
    n_checks++;
    if (first_q != SYNC_STAGES + STABLE_CYCLES) begin
      n_fail++;
      $display("FAIL post_abort latency: got %0d edges expected %0d", first_q,
               SYNC_STAGES + STABLE_CYCLES);
    end

    // Randomized slowly-changing input with random tick gaps and rare resets.
    din = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) din = ~din;
      if ($urandom_range(0, 150) == 0) begin
        rst = 1'b0;
        model_reset();
        #1;
        check("rand reset q", q, 1'b0);
        #1;
        rst = 1'b1;
      end
      cycle(din, $urandom_range(0, 3) != 0, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
